// File: rtl/piggy_pkg.sv
// Shared definitions for the piggy-bank coin front end: FSM states and default widths.
package piggy_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_e;

    localparam int DENOM_W    = 8;
    localparam int TOTAL_W_DEF = 16;
    localparam int PEND_W_DEF  = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting slot after last_grant, with wrap-around.
module rr_arbiter #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2
) (
    input  logic [NUM_SLOTS-1:0] req,
    input  logic [SLOT_W-1:0]    last_grant,
    output logic                 gnt_valid,
    output logic [SLOT_W-1:0]    gnt_idx
);

    logic [SLOT_W-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int off = 1; off <= NUM_SLOTS; off++) begin
            idx = SLOT_W'((int'(last_grant) + off) % NUM_SLOTS);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/coin_slot_scheduler.sv
// Multi-slot coin front end: edge detect, per-slot pending queues, round-robin adder, withdraw sequencing.
// Optional goal comparator enabled by defining GOAL_EN.
module coin_slot_scheduler
    import piggy_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int TOTAL_W   = TOTAL_W_DEF,
    parameter int PEND_W    = PEND_W_DEF,
    localparam int SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SLOTS-1:0]         coin_in,
    input  logic [DENOM_W*NUM_SLOTS-1:0] denom_cfg,
    input  logic                         withdraw_req,
    output logic [TOTAL_W-1:0]           total,
    output logic                         add_valid,
    output logic [SLOT_W-1:0]            add_slot,
    output logic [NUM_SLOTS-1:0]         dropped,
    output logic                         overflow_err,
    output logic                         busy,
    output logic                         withdraw_done,
    output logic [TOTAL_W-1:0]           withdraw_amount
`ifdef GOAL_EN
    ,
    input  logic [TOTAL_W-1:0]           goal_cfg,
    output logic                         goal_reached
`endif
);

    localparam logic [PEND_W-1:0] PEND_MAX   = '1;
    localparam logic [SLOT_W-1:0] LAST_RESET = SLOT_W'(NUM_SLOTS - 1);

    state_e                 state_q, state_d;
    logic [NUM_SLOTS-1:0]   coin_prev_q;
    logic [NUM_SLOTS-1:0]   edges;
    logic [NUM_SLOTS-1:0]   req;
    logic [PEND_W-1:0]      pending_q [NUM_SLOTS];
    logic [PEND_W-1:0]      pending_d [NUM_SLOTS];
    logic [SLOT_W-1:0]      last_grant_q, last_grant_d;
    logic [SLOT_W-1:0]      gnt_idx;
    logic                   gnt_valid;
    logic                   grant_en;
    logic                   accept, take;
    logic [DENOM_W-1:0]     denom_sel;
    logic [TOTAL_W:0]       sum;
    logic [TOTAL_W-1:0]     total_q, total_d;
    logic [TOTAL_W-1:0]     amount_q, amount_d;
    logic [NUM_SLOTS-1:0]   dropped_q, dropped_d;
    logic [SLOT_W-1:0]      add_slot_q, add_slot_d;
    logic                   add_valid_q, add_valid_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;

    assign edges = coin_in & ~coin_prev_q;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            req[i] = (pending_q[i] != '0);
        end
    end

    rr_arbiter #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    // No grants in CLEAR; pending is already empty there, this just keeps the adder quiet.
    assign grant_en  = gnt_valid && (state_q != CLEAR);
    assign denom_sel = denom_cfg[int'(gnt_idx)*DENOM_W +: DENOM_W];
    assign sum       = {1'b0, total_q} + (TOTAL_W+1)'(denom_sel);

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        last_grant_d = last_grant_q;
        total_d      = total_q;
        amount_d     = amount_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;
        dropped_d    = '0;
        add_valid_d  = grant_en;
        add_slot_d   = grant_en ? gnt_idx : '0;
        accept       = 1'b0;
        take         = 1'b0;

        for (int i = 0; i < NUM_SLOTS; i++) begin
            accept       = edges[i] && (state_q == RUN) && (pending_q[i] != PEND_MAX);
            take         = grant_en && (gnt_idx == SLOT_W'(i));
            dropped_d[i] = edges[i] && !accept;
            if (accept && !take) begin
                pending_d[i] = pending_q[i] + 1'b1;
            end else if (!accept && take) begin
                pending_d[i] = pending_q[i] - 1'b1;
            end
        end

        if (grant_en) begin
            last_grant_d = gnt_idx;
            if (sum[TOTAL_W]) begin
                total_d = '1;
                ovf_d   = 1'b1;
            end else begin
                total_d = sum[TOTAL_W-1:0];
            end
        end

        case (state_q)
            RUN: begin
                if (withdraw_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (req == '0) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                amount_d = total_q;
                total_d  = '0;
                ovf_d    = 1'b0;
                done_d   = 1'b1;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Previous coin level resets high so a coin held through reset release is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            coin_prev_q  <= '1;
            last_grant_q <= LAST_RESET;
            total_q      <= '0;
            amount_q     <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            dropped_q    <= '0;
            add_valid_q  <= 1'b0;
            add_slot_q   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pending_q[i] <= '0;
            end
        end else begin
            coin_prev_q  <= coin_in;
            last_grant_q <= last_grant_d;
            total_q      <= total_d;
            amount_q     <= amount_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
            dropped_q    <= dropped_d;
            add_valid_q  <= add_valid_d;
            add_slot_q   <= add_slot_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pending_q[i] <= pending_d[i];
            end
        end
    end

`ifdef GOAL_EN
    logic goal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            goal_q <= 1'b0;
        end else if (state_q == CLEAR) begin
            goal_q <= 1'b0;
        end else if ((goal_cfg != '0) && (total_q >= goal_cfg)) begin
            goal_q <= 1'b1;
        end
    end

    assign goal_reached = goal_q;
`endif

    assign total           = total_q;
    assign add_valid       = add_valid_q;
    assign add_slot        = add_slot_q;
    assign dropped         = dropped_q;
    assign overflow_err    = ovf_q;
    assign busy            = (state_q == DRAIN) || (state_q == CLEAR);
    assign withdraw_done   = done_q;
    assign withdraw_amount = amount_q;

endmodule

// File: tb/tb_coin_slot_scheduler.sv
// Directed bench for coin_slot_scheduler: per-cycle vector table plus contention and overflow sequences.
module tb_coin_slot_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  coin_a, coin_b;
    logic        wd_a, wd_b;
    logic [31:0] denom;

    logic [15:0] total_a, amt_a;
    logic        av_a, ovf_a, busy_a, done_a;
    logic [1:0]  slot_a;
    logic [3:0]  drop_a;

    logic [7:0]  total_b, amt_b;
    logic        av_b, ovf_b, busy_b, done_b;
    logic [1:0]  slot_b;
    logic [3:0]  drop_b;

    int n_pass  = 0;
    int n_total = 0;

    coin_slot_scheduler #(.NUM_SLOTS(4), .TOTAL_W(16), .PEND_W(3)) dut_a (
        .clk (clk), .reset (reset), .coin_in (coin_a), .denom_cfg (denom),
        .withdraw_req (wd_a), .total (total_a), .add_valid (av_a), .add_slot (slot_a),
        .dropped (drop_a), .overflow_err (ovf_a), .busy (busy_a),
        .withdraw_done (done_a), .withdraw_amount (amt_a)
    );

    coin_slot_scheduler #(.NUM_SLOTS(4), .TOTAL_W(8), .PEND_W(3)) dut_b (
        .clk (clk), .reset (reset), .coin_in (coin_b), .denom_cfg (denom),
        .withdraw_req (wd_b), .total (total_b), .add_valid (av_b), .add_slot (slot_b),
        .dropped (drop_b), .overflow_err (ovf_b), .busy (busy_b),
        .withdraw_done (done_b), .withdraw_amount (amt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] coin;
        logic       wd;
        logic       av;
        int         slot;
        int         tot;
        logic [3:0] drop;
        logic       busy;
        logic       done;
        int         amt;
        logic       ovf;
    } vec_t;

    vec_t tv[$];

    task automatic add_row(input logic rst, input logic [3:0] coin, input logic wd,
                           input logic av, input int slot, input int tot, input logic [3:0] drop,
                           input logic busy, input logic done, input int amt, input logic ovf);
        vec_t v;
        v.rst = rst; v.coin = coin; v.wd = wd; v.av = av; v.slot = slot; v.tot = tot;
        v.drop = drop; v.busy = busy; v.done = done; v.amt = amt; v.ovf = ovf;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int grants [4];
    int drops  [4];
    int exp_total;
    int denoms [4] = '{1, 5, 10, 25};

    initial begin
        reset = 1'b1;
        coin_a = '0; coin_b = '0; wd_a = 1'b0; wd_b = 1'b0;
        denom = {8'd25, 8'd10, 8'd5, 8'd1};

        //       rst coin  wd   av slot tot  drop  busy done amt ovf
        add_row(1, 4'h0, 0,   0, 0,  0,   4'h0, 0, 0,  0, 0);
        add_row(1, 4'h0, 0,   0, 0,  0,   4'h0, 0, 0,  0, 0);
        add_row(0, 4'h0, 0,   0, 0,  0,   4'h0, 0, 0,  0, 0);
        add_row(0, 4'h4, 0,   0, 0,  0,   4'h0, 0, 0,  0, 0);
        add_row(0, 4'h4, 0,   1, 2,  10,  4'h0, 0, 0,  0, 0);
        add_row(0, 4'h0, 0,   0, 0,  10,  4'h0, 0, 0,  0, 0);
        // coin held high across reset release must not count
        add_row(1, 4'h8, 0,   0, 0,  0,   4'h0, 0, 0,  0, 0);
        add_row(0, 4'h8, 0,   0, 0,  0,   4'h0, 0, 0,  0, 0);
        add_row(0, 4'h0, 0,   0, 0,  0,   4'h0, 0, 0,  0, 0);
        add_row(0, 4'hF, 0,   0, 0,  0,   4'h0, 0, 0,  0, 0);
        add_row(0, 4'h0, 0,   1, 0,  1,   4'h0, 0, 0,  0, 0);
        add_row(0, 4'h0, 0,   1, 1,  6,   4'h0, 0, 0,  0, 0);
        add_row(0, 4'h0, 0,   1, 2,  16,  4'h0, 0, 0,  0, 0);
        add_row(0, 4'h0, 0,   1, 3,  41,  4'h0, 0, 0,  0, 0);
        add_row(0, 4'h0, 0,   0, 0,  41,  4'h0, 0, 0,  0, 0);
        // withdraw with two coins queued, edge on slot0 during DRAIN
        add_row(0, 4'h3, 1,   0, 0,  41,  4'h0, 1, 0,  0, 0);
        add_row(0, 4'h0, 0,   1, 0,  42,  4'h0, 1, 0,  0, 0);
        add_row(0, 4'h1, 0,   1, 1,  47,  4'h1, 1, 0,  0, 0);
        add_row(0, 4'h0, 1,   0, 0,  47,  4'h0, 1, 0,  0, 0);
        add_row(0, 4'h0, 0,   0, 0,  0,   4'h0, 0, 1,  47, 0);
        add_row(0, 4'h0, 0,   0, 0,  0,   4'h0, 0, 0,  47, 0);
        // reset in the second DRAIN cycle
        add_row(0, 4'h6, 1,   0, 0,  0,   4'h0, 1, 0,  47, 0);
        add_row(0, 4'h0, 0,   1, 2,  10,  4'h0, 1, 0,  47, 0);
        add_row(1, 4'h0, 0,   0, 0,  0,   4'h0, 0, 0,  0, 0);
        add_row(0, 4'h0, 0,   0, 0,  0,   4'h0, 0, 0,  0, 0);
        add_row(0, 4'h0, 0,   0, 0,  0,   4'h0, 0, 0,  0, 0);

        for (int r = 0; r < tv.size(); r++) begin
            reset = tv[r].rst; coin_a = tv[r].coin; wd_a = tv[r].wd;
            tick;
            chk($sformatf("r%0d add_valid", r), int'(av_a), int'(tv[r].av));
            if (tv[r].av) chk($sformatf("r%0d add_slot", r), int'(slot_a), tv[r].slot);
            chk($sformatf("r%0d total", r), int'(total_a), tv[r].tot);
            chk($sformatf("r%0d dropped", r), int'(drop_a), int'(tv[r].drop));
            chk($sformatf("r%0d busy", r), int'(busy_a), int'(tv[r].busy));
            chk($sformatf("r%0d withdraw_done", r), int'(done_a), int'(tv[r].done));
            chk($sformatf("r%0d withdraw_amount", r), int'(amt_a), tv[r].amt);
            chk($sformatf("r%0d overflow_err", r), int'(ovf_a), int'(tv[r].ovf));
        end
        wd_a = 1'b0;

        // overflow on the 8-bit instance: 11 coins of 25 on slot3
        for (int k = 1; k <= 11; k++) begin
            coin_b = 4'h8; tick;
            coin_b = 4'h0; tick;
            chk($sformatf("ovf coin%0d add_valid", k), int'(av_b), 1);
            chk($sformatf("ovf coin%0d total", k), int'(total_b), (k <= 10) ? 25 * k : 255);
            chk($sformatf("ovf coin%0d overflow_err", k), int'(ovf_b), (k == 11) ? 1 : 0);
        end

        // contention: all slots toggle every 2 cycles; every edge is either granted or dropped
        reset = 1'b1; coin_a = '0; tick;
        reset = 1'b0; tick;
        for (int i = 0; i < 4; i++) begin grants[i] = 0; drops[i] = 0; end
        for (int c = 0; c < 100; c++) begin
            coin_a = (c < 40 && (c % 2) == 0) ? 4'hF : 4'h0;
            tick;
            if (av_a) grants[slot_a]++;
            for (int i = 0; i < 4; i++) if (drop_a[i]) drops[i]++;
        end
        exp_total = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("toggle slot%0d granted+dropped", i), grants[i] + drops[i], 20);
            chk($sformatf("toggle slot%0d saw drops", i), int'(drops[i] > 0), 1);
            exp_total += grants[i] * denoms[i];
        end
        chk("toggle final total", int'(total_a), exp_total);
        chk("toggle queues drained", int'(av_a), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
